// File: rtl/exp_request_ctrl_pkg.sv
// Shared types and helpers for the exception-request front end.
package exp_request_ctrl_pkg;

   localparam int N_SRC = 3;
   localparam logic [1:0] NO_SERVICE = 2'd3;

   typedef logic [N_SRC-1:0] src_vec_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // Bit 2 has the highest priority; caller guarantees v != 0.
   function automatic logic [1:0] highest_index(input src_vec_t v);
      if (v[2])
         return 2'd2;
      else if (v[1])
         return 2'd1;
      else
         return 2'd0;
   endfunction

   function automatic src_vec_t onehot(input logic [1:0] idx);
      return src_vec_t'(1) << idx;
   endfunction

endpackage

// File: rtl/exp_request_ctrl_debounce.sv
// Single-bit front end: 2-flop synchronizer, run-length debounce filter and
// rising-edge detector on the filtered level.
module exp_debounce #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             filt_reg;
   logic             filt_d_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         filt_reg   <= 1'b0;
         filt_d_reg <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         sync1_reg  <= raw;
         sync2_reg  <= sync1_reg;
         filt_d_reg <= filt_reg;
         // Any cycle agreeing with the filtered level restarts the run.
         if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign rise = filt_reg & ~filt_d_reg;

endmodule

// File: rtl/exp_request_ctrl.sv
// Latches debounced event edges and presents them one at a time, highest
// index first, on the CPU exception-source lines with a HasExp/IsEret handshake.
module exp_request_ctrl
   import exp_request_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] raw_in,
   input  logic       has_exp,
   input  logic       is_eret,
   output logic [2:0] exp_src,
   output logic [2:0] pending,
   output logic [1:0] service_id,
   output logic       busy,
   output logic [2:0] overrun
);

   src_vec_t   rise;
   state_t     state_reg, state_next;
   logic [1:0] sel_reg, sel_next;
   src_vec_t   exp_src_reg, exp_src_next;
   logic [1:0] service_id_reg, service_id_next;
   src_vec_t   pending_reg, pending_next;
   src_vec_t   overrun_reg, overrun_next;
   src_vec_t   ack_mask;

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
         exp_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
         ) u_debounce (
            .clk (clk),
            .rst (rst),
            .raw (raw_in[gi]),
            .rise(rise[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      sel_next        = sel_reg;
      exp_src_next    = exp_src_reg;
      service_id_next = service_id_reg;
      ack_mask        = '0;
      case (state_reg)
         ST_IDLE: begin
            if (|pending_reg) begin
               sel_next        = highest_index(pending_reg);
               exp_src_next    = onehot(sel_next);
               service_id_next = sel_next;
               state_next      = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (has_exp) begin
               ack_mask     = onehot(sel_reg);
               exp_src_next = '0;
               state_next   = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            if (is_eret) begin
               service_id_next = NO_SERVICE;
               state_next      = ST_IDLE;
            end
         end
         default: begin
            exp_src_next    = '0;
            service_id_next = NO_SERVICE;
            state_next      = ST_IDLE;
         end
      endcase
      // A fresh edge beats the acknowledge of the same bit and is not an overrun.
      pending_next = (pending_reg & ~ack_mask) | rise;
      overrun_next = overrun_reg | (rise & pending_reg & ~ack_mask);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         sel_reg        <= 2'd0;
         exp_src_reg    <= '0;
         service_id_reg <= NO_SERVICE;
         pending_reg    <= '0;
         overrun_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         sel_reg        <= sel_next;
         exp_src_reg    <= exp_src_next;
         service_id_reg <= service_id_next;
         pending_reg    <= pending_next;
         overrun_reg    <= overrun_next;
      end
   end

   assign exp_src    = exp_src_reg;
   assign pending    = pending_reg;
   assign service_id = service_id_reg;
   assign overrun    = overrun_reg;
   assign busy       = (state_reg != ST_IDLE);

endmodule
